// File: rtl/mul_share_arbiter.sv
// mul_share_arbiter
// Shares one sequential multiplier among NUM_REQ requesters. Requesters are
// served in round-robin order. The block drives the multiplier's Start/Ready
// handshake and returns each product tagged with the owning requester index.
// Optional feature: define MUL_ZERO_BYPASS_EN to answer zero-operand pairs
// directly from IDLE with a zero product, without using the multiplier.
module mul_share_arbiter #(
  parameter  int DP_WIDTH = 5,
  parameter  int NUM_REQ  = 4,
  localparam int ID_W     = $clog2(NUM_REQ)
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic [NUM_REQ-1:0]          req_valid,
  input  logic [NUM_REQ*DP_WIDTH-1:0] req_multiplicand,
  input  logic [NUM_REQ*DP_WIDTH-1:0] req_multiplier,
  output logic [NUM_REQ-1:0]          req_ready,
  output logic                        rsp_valid,
  output logic [ID_W-1:0]             rsp_id,
  output logic [2*DP_WIDTH-1:0]       rsp_product,
  output logic                        mul_start,
  output logic [DP_WIDTH-1:0]         mul_multiplicand,
  output logic [DP_WIDTH-1:0]         mul_multiplier,
  input  logic                        mul_ready,
  input  logic [2*DP_WIDTH-1:0]       mul_product
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_BUSY, WAIT_DONE} state_t;

  state_t              state;
  logic [ID_W-1:0]     rr_ptr;
  logic [ID_W-1:0]     cur_id;
  logic [ID_W-1:0]     grant_id;
  logic [ID_W-1:0]     rr_next;
  logic                grant_found;
  logic                accept;
  logic                bypass;
  logic [DP_WIDTH-1:0] grant_a;
  logic [DP_WIDTH-1:0] grant_b;

  // Round-robin search: first asserted request at or above rr_ptr, with wrap.
  always_comb begin
    logic [ID_W-1:0] idx;
    // NOTE: every variable written here gets a default first so no latch is inferred.
    idx         = '0;
    grant_found = 1'b0;
    grant_id    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = ID_W'((int'(rr_ptr) + k) % NUM_REQ);
      if (!grant_found && req_valid[idx]) begin
        grant_found = 1'b1;
        grant_id    = idx;
      end
    end
  end

  assign grant_a = req_multiplicand[int'(grant_id)*DP_WIDTH +: DP_WIDTH];
  assign grant_b = req_multiplier[int'(grant_id)*DP_WIDTH +: DP_WIDTH];
  assign rr_next = (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;

  // Accept decision and the one-hot ready strobe for the granted requester.
  always_comb begin
`ifdef MUL_ZERO_BYPASS_EN
    bypass = (grant_a == '0) || (grant_b == '0);
`else
    bypass = 1'b0;
`endif
    accept    = (state == IDLE) && grant_found && (mul_ready || bypass);
    req_ready = '0;
    if (accept) begin
      req_ready[grant_id] = 1'b1;
    end
  end

  // Sequencer: accept, issue Start, wait for the multiplier, return the result.
  always_ff @(posedge clock) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (reset) begin
      state            <= IDLE;
      rr_ptr           <= '0;
      cur_id           <= '0;
      mul_start        <= 1'b0;
      mul_multiplicand <= '0;
      mul_multiplier   <= '0;
      rsp_valid        <= 1'b0;
      rsp_id           <= '0;
      rsp_product      <= '0;
    end else begin
      rsp_valid <= 1'b0;
      mul_start <= 1'b0;
      unique case (state)
        IDLE: begin
          if (accept) begin
            rr_ptr <= rr_next;
            if (bypass) begin
              // Zero operand: answer straight away, multiplier untouched.
              rsp_valid   <= 1'b1;
              rsp_id      <= grant_id;
              rsp_product <= '0;
            end else begin
              mul_multiplicand <= grant_a;
              mul_multiplier   <= grant_b;
              cur_id           <= grant_id;
              mul_start        <= 1'b1;
              state            <= ISSUE;
            end
          end
        end
        ISSUE: begin
          state <= WAIT_BUSY;
        end
        WAIT_BUSY: begin
          // Ready dropping shows the multiplier took the Start pulse.
          if (!mul_ready) begin
            state <= WAIT_DONE;
          end
        end
        WAIT_DONE: begin
          if (mul_ready) begin
            rsp_valid   <= 1'b1;
            rsp_id      <= cur_id;
            rsp_product <= mul_product;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mul_share_arbiter.sv
// tb_mul_share_arbiter
// Self-checking bench for mul_share_arbiter with a behavioural multiplier
// model. A transaction-level monitor predicts grants and responses from the
// round-robin rule, a one-outstanding-operation flag and plain multiplication.
// Honours MUL_ZERO_BYPASS_EN when defined.
module tb_mul_share_arbiter;

  localparam int W    = 5;
  localparam int N    = 4;
  localparam int ID_W = $clog2(N);
`ifdef MUL_ZERO_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic [N-1:0]      req_valid = '0;
  logic [N*W-1:0]    req_multiplicand = '0;
  logic [N*W-1:0]    req_multiplier = '0;
  logic [N-1:0]      req_ready;
  logic              rsp_valid;
  logic [ID_W-1:0]   rsp_id;
  logic [2*W-1:0]    rsp_product;
  logic              mul_start;
  logic [W-1:0]      mul_multiplicand;
  logic [W-1:0]      mul_multiplier;
  logic              mul_ready = 1'b1;
  logic [2*W-1:0]    mul_product = '0;

  int errors = 0;
  int checks = 0;

  mul_share_arbiter #(.DP_WIDTH(W), .NUM_REQ(N)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_multiplicand(req_multiplicand),
    .req_multiplier(req_multiplier), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_product(rsp_product),
    .mul_start(mul_start), .mul_multiplicand(mul_multiplicand),
    .mul_multiplier(mul_multiplier), .mul_ready(mul_ready),
    .mul_product(mul_product)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural multiplier: takes Start while idle, busy for a few cycles,
  // then presents the full product with Ready high. Not reset by the bench.
  int             mm_lat_fixed = 0;
  int             mm_cnt = 0;
  logic [2*W-1:0] mm_res = '0;
  always @(posedge clock) begin
    if (mul_ready && mul_start) begin
      mul_ready   <= 1'b0;
      mm_cnt      <= (mm_lat_fixed != 0) ? mm_lat_fixed : int'($urandom_range(1, 5));
      mm_res      <= (2*W)'(mul_multiplicand) * (2*W)'(mul_multiplier);
      mul_product <= (2*W)'($urandom);
    end else if (!mul_ready) begin
      if (mm_cnt <= 1) begin
        mul_ready   <= 1'b1;
        mul_product <= mm_res;
      end else begin
        mm_cnt <= mm_cnt - 1;
      end
    end
  end

  // Transaction-level reference: pointer, one outstanding operation.
  int             cyc = 0;
  int             exp_ptr = 0;
  bit             outst = 1'b0;
  bit             need_start = 1'b0;
  bit             started = 1'b0;
  int             exp_id = 0;
  int             acc_cyc = 0;
  logic [W-1:0]   exp_a = '0;
  logic [W-1:0]   exp_b = '0;
  logic [2*W-1:0] exp_prod = '0;
  logic [N-1:0]   acc_mask = '0;
  int             grant_log[$];

  always @(posedge clock) begin
    cyc++;
    if (reset) begin
      exp_ptr  = 0;
      outst    = 1'b0;
      acc_mask = '0;
    end
  end

  always @(negedge clock) begin
    if (!reset) begin
      logic [N-1:0]   exp_mask;
      logic [W-1:0]   ga, gb;
      logic [2*W-1:0] wa, wb;
      int             g;
      bit             found;
      acc_mask = req_valid & req_ready;
      if (rsp_valid) begin
        if (!outst) begin
          check("rsp_unexpected", rsp_valid, 0);
        end else begin
          check("rsp_id", rsp_id, exp_id);
          check("rsp_product", rsp_product, exp_prod);
          check("start_per_rsp", started, need_start);
          if (!need_start) check("bypass_latency", cyc - acc_cyc, 1);
          outst = 1'b0;
        end
      end
      if (mul_start) begin
        if (!outst || !need_start || started) begin
          check("spurious_start", mul_start, 0);
        end else begin
          check("mul_multiplicand", mul_multiplicand, exp_a);
          check("mul_multiplier", mul_multiplier, exp_b);
          started = 1'b1;
        end
      end
      exp_mask = '0;
      found = 1'b0;
      g = 0;
      ga = '0;
      gb = '0;
      if (!outst) begin
        for (int k = 0; k < N; k++) begin
          if (!found && req_valid[(exp_ptr + k) % N]) begin
            found = 1'b1;
            g = (exp_ptr + k) % N;
          end
        end
        if (found) begin
          ga = req_multiplicand[g*W +: W];
          gb = req_multiplier[g*W +: W];
          if (mul_ready || (BYP && (ga == 0 || gb == 0))) exp_mask[g] = 1'b1;
        end
      end
      if (req_ready != 0 || exp_mask != 0) check("req_ready", req_ready, exp_mask);
      if (exp_mask != 0 && req_ready == exp_mask) begin
        wa = (2*W)'(ga);
        wb = (2*W)'(gb);
        outst      = 1'b1;
        exp_id     = g;
        exp_a      = ga;
        exp_b      = gb;
        exp_prod   = wa * wb;
        need_start = !(BYP && (ga == 0 || gb == 0));
        started    = 1'b0;
        acc_cyc    = cyc;
        exp_ptr    = (g + 1) % N;
        grant_log.push_back(g);
      end
      if (outst && (cyc - acc_cyc > 40)) begin
        check("rsp_timeout", outst, 0);
        outst = 1'b0;
      end
    end
  end

  typedef struct {
    int             id;
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic [2*W-1:0] p;
  } vec_t;

  task automatic do_reset();
    @(posedge clock); #1;
    reset = 1'b1;
    req_valid = '0;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
  endtask

  task automatic set_ops(input int id, input logic [W-1:0] a, input logic [W-1:0] b);
    req_multiplicand[id*W +: W] = a;
    req_multiplier[id*W +: W]   = b;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req_ready"}, req_ready, 0);
    check({tag, "_mul_start"}, mul_start, 0);
    check({tag, "_rsp_valid"}, rsp_valid, 0);
    check({tag, "_rsp_id"}, rsp_id, 0);
    check({tag, "_rsp_product"}, rsp_product, 0);
    check({tag, "_mul_multiplicand"}, mul_multiplicand, 0);
    check({tag, "_mul_multiplier"}, mul_multiplier, 0);
  endtask

  task automatic single_op(input vec_t v);
    int           n_start;
    bit           seen;
    logic [N-1:0] onehot;
    onehot = '0;
    onehot[v.id] = 1'b1;
    @(posedge clock); #1;
    set_ops(v.id, v.a, v.b);
    req_valid = onehot;
    seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge clock);
      if (req_ready != 0) begin
        seen = 1'b1;
        check("tbl_req_ready", req_ready, onehot);
      end
    end
    check("tbl_accept_seen", seen, 1);
    @(posedge clock); #1;
    req_valid = '0;
    seen = 1'b0;
    n_start = 0;
    for (int c = 0; c < 40 && !seen; c++) begin
      @(negedge clock);
      if (mul_start) n_start++;
      if (rsp_valid) begin
        seen = 1'b1;
        check("tbl_rsp_id", rsp_id, v.id);
        check("tbl_rsp_product", rsp_product, v.p);
      end
    end
    check("tbl_rsp_seen", seen, 1);
    check("tbl_start_count", n_start, (BYP && (v.a == 0 || v.b == 0)) ? 0 : 1);
  endtask

  task automatic wait_grants(input int n, input bit drop);
    int c = 0;
    while (grant_log.size() < n && c < 200) begin
      @(posedge clock); #1;
      if (drop) req_valid = req_valid & ~acc_mask;
      c++;
    end
    check("grant_wait", grant_log.size() >= n, 1);
  endtask

  task automatic wait_idle();
    int c = 0;
    while (outst && c < 100) begin
      @(posedge clock); #1;
      c++;
    end
    check("idle_wait", outst, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[6];
    int   n_rsp;
    tbl[0] = '{id: 2, a: 5'b10111, b: 5'b10011, p: 10'd437};
    tbl[1] = '{id: 1, a: 5'b11111, b: 5'b11111, p: 10'd961};
    tbl[2] = '{id: 0, a: 5'b00000, b: 5'b10011, p: 10'd0};
    tbl[3] = '{id: 3, a: 5'd7,     b: 5'd0,     p: 10'd0};
    tbl[4] = '{id: 0, a: 5'd1,     b: 5'd1,     p: 10'd1};
    tbl[5] = '{id: 3, a: 5'd31,    b: 5'd1,     p: 10'd31};

    // Reset state.
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    check_reset_outputs("rst");

    // Table-driven single requests.
    foreach (tbl[i]) single_op(tbl[i]);
    wait_idle();

    // All four request from reset and hold valid: 0,1,2,3,0.
    do_reset();
    grant_log.delete();
    for (int i = 0; i < N; i++) set_ops(i, W'(i + 3), W'(2*i + 5));
    req_valid = '1;
    wait_grants(5, 1'b0);
    req_valid = '0;
    for (int i = 0; i < 5; i++) check("hold_order", grant_log[i], i % N);
    wait_idle();

    // Round-robin from a non-zero pointer: grant 1, then 0 and 3 -> 3 first.
    do_reset();
    single_op('{id: 1, a: 5'd3, b: 5'd4, p: 10'd12});
    wait_idle();
    grant_log.delete();
    set_ops(0, 5'd9, 5'd9);
    set_ops(3, 5'd6, 5'd11);
    req_valid = 4'b1001;
    wait_grants(2, 1'b1);
    req_valid = '0;
    check("rr_first", grant_log[0], 3);
    check("rr_second", grant_log[1], 0);
    wait_idle();

    // Reset during WAIT_DONE discards the result and clears the pointer.
    do_reset();
    single_op('{id: 2, a: 5'd13, b: 5'd17, p: 10'd221});
    wait_idle();
    mm_lat_fixed = 10;
    grant_log.delete();
    set_ops(1, 5'd21, 5'd22);
    req_valid = 4'b0010;
    wait_grants(1, 1'b1);
    repeat (3) @(posedge clock);
    #1 reset = 1'b1;
    @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    check_reset_outputs("midrst");
    n_rsp = 0;
    for (int c = 0; c < 15; c++) begin
      @(negedge clock);
      if (rsp_valid) n_rsp++;
    end
    check("midrst_no_rsp", n_rsp, 0);
    mm_lat_fixed = 0;
    grant_log.delete();
    for (int i = 0; i < N; i++) set_ops(i, W'(i + 1), 5'd3);
    @(posedge clock); #1;
    req_valid = '1;
    wait_grants(1, 1'b1);
    req_valid = '0;
    check("midrst_next_grant", grant_log[0], 0);
    wait_idle();

    // Randomised traffic against the reference monitor.
    for (int c = 0; c < 3000; c++) begin
      @(posedge clock); #1;
      for (int i = 0; i < N; i++) begin
        if (acc_mask[i] || !req_valid[i]) begin
          req_valid[i] = ($urandom_range(0, 2) != 0);
          if (req_valid[i]) begin
            case ($urandom_range(0, 7))
              0:       req_multiplicand[i*W +: W] = '0;
              1:       req_multiplicand[i*W +: W] = '1;
              default: req_multiplicand[i*W +: W] = W'($urandom);
            endcase
            case ($urandom_range(0, 7))
              0:       req_multiplier[i*W +: W] = '0;
              1:       req_multiplier[i*W +: W] = '1;
              default: req_multiplier[i*W +: W] = W'($urandom);
            endcase
          end
        end else if ($urandom_range(0, 15) == 0) begin
          req_valid[i] = 1'b0;
        end
      end
    end
    req_valid = '0;
    wait_idle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mul_share_arbiter.md
# mul_share_arbiter

Round-robin arbiter and sequencer that shares one `Sequential_Binary_Multiplier` instance among `NUM_REQ` requesters. It accepts one operand pair at a time and drives the multiplier's Start/Ready handshake. It returns the product tagged with the requester index. It sits between client blocks and the multiplier datapath and is the only block that drives the multiplier's operand and Start inputs.

## Interface
- `DP_WIDTH`, 5: multiplier datapath width; product is `2*DP_WIDTH` bits.
- `NUM_REQ`, 4: number of requesters (2..8); `ID_W = $clog2(NUM_REQ)`.

Ports:
- `clock` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high reset.
- `req_valid` in `NUM_REQ`: per-requester request.
- `req_multiplicand` in `NUM_REQ*DP_WIDTH`: packed operands; slice i belongs to requester i.
- `req_multiplier` in `NUM_REQ*DP_WIDTH`: packed operands, same layout.
- `req_ready` out `NUM_REQ`: one-hot accept strobe. A transfer happens on an edge where `req_valid[i] & req_ready[i]`.
- `rsp_valid` out 1: one-cycle result strobe.
- `rsp_id` out `ID_W`: index of the requester that owns the result.
- `rsp_product` out `2*DP_WIDTH`: result.
- `mul_start` out 1: to multiplier Start.
- `mul_multiplicand` out `DP_WIDTH`: to multiplier.
- `mul_multiplier` out `DP_WIDTH`: to multiplier.
- `mul_ready` in 1: from multiplier Ready (high when idle).
- `mul_product` in `2*DP_WIDTH`: from multiplier Product.

## Operation
- States: IDLE, ISSUE, WAIT_BUSY, WAIT_DONE.
- **IDLE**
  - If any `req_valid` and `mul_ready`=1: grant the first asserted index, searching from `rr_ptr` upward with wrap.
  - `req_ready[grant]`=1 combinationally in this cycle only.
  - On the edge: latch operands and grant id; set `rr_ptr` = (grant+1) mod `NUM_REQ`; go to ISSUE.
- **ISSUE**
  - `mul_start`=1 for exactly one cycle, with the latched operands on `mul_*`.
  - Next state is WAIT_BUSY.
- **WAIT_BUSY**
  - Stay until `mul_ready`=0, which shows the multiplier accepted Start; then go to WAIT_DONE.
- **WAIT_DONE**
  - On `mul_ready`=1: capture `mul_product` into `rsp_product`, set `rsp_id`, pulse `rsp_valid` in the following cycle, and go to IDLE.
- Operand outputs `mul_multiplicand`/`mul_multiplier` hold their latched values from ISSUE until the next accept.
- `rsp_product`/`rsp_id` hold their last value after the `rsp_valid` pulse.
- The product is not recomputed or truncated: `rsp_product` = `mul_product`, full `2*DP_WIDTH` bits.
- Requesters must hold operands stable while `req_valid` is high and not yet accepted. Dropping `req_valid` before grant is legal and is simply skipped.
- No new grant is made while the multiplier is busy. At most one operation is outstanding.

## Timing
- Reset values:
  - state IDLE, `rr_ptr`=0.
  - `req_ready`=0, `mul_start`=0, `rsp_valid`=0.
  - `rsp_id`=0, `rsp_product`=0, `mul_multiplicand`=0, `mul_multiplier`=0.
- Accept edge T0: `mul_start` is high during cycle T0→T1, and the multiplier samples it at T1.
- Response: `rsp_valid` is high in the cycle after the edge on which WAIT_DONE sees `mul_ready`=1.
- Arbiter overhead is 1 cycle before Start plus 1 cycle after Ready, on top of the multiplier latency.
- The `rsp_valid` cycle is an IDLE cycle, so a new accept may coincide with `rsp_valid`. Back-to-back service is required.
- A requester whose `req_valid` stays high after its accept is treated as a new request; round-robin order still applies.
- Reset mid-operation (any state):
  - Outputs return to their reset values on the next edge and `rr_ptr`=0.
  - A pending result is discarded; `rsp_valid` is never raised for it.
  - The multiplier is reset from the same system reset, inverted to its active-low `reset_b` at integration.

## Configuration
- `MUL_ZERO_BYPASS_EN` defined:
  - An accepted pair with either operand = 0 skips the multiplier: no `mul_start`, and `mul_*` operand outputs are not updated.
  - `rsp_valid` goes high in the cycle after the accept edge with `rsp_product`=0 and the correct `rsp_id`.
  - The FSM stays in IDLE, and the bypass accept does not require `mul_ready`=1.
- Undefined: zero operands go through the normal ISSUE/WAIT path with no special case.

## Test plan
- **Single request:** `DP_WIDTH`=5, `NUM_REQ`=4. Requester 2 requests 10111×10011 → one-cycle `req_ready`=0100, one `mul_start` pulse carrying 10111/10011, then `rsp_valid` with `rsp_id`=2 and `rsp_product`=0110110101 (437).
- **All four request from reset and hold valid:** grants in order 0,1,2,3,0, each with exactly one `mul_start` per `rsp_valid`. No `req_ready` while the FSM is outside IDLE.
- **Round-robin search from a non-zero pointer:** after granting 1 (`rr_ptr`=2), requests on 0 and 3 → 3 is granted first, then 0.
- **Maximum operands:** 11111×11111 → `rsp_product`=1111000001 (961).
- **Zero operand, 00000×10011:**
  - With `MUL_ZERO_BYPASS_EN`: `rsp_valid` one cycle after accept, product 0, `mul_start` never high.
  - Without it: the normal path is taken and the product is 0.
- **Reset mid-operation:** assert `reset` for 1 cycle during WAIT_DONE → next cycle all outputs are at reset values. The subsequent rise of `mul_ready` produces no `rsp_valid`, and the next grant starts from index 0.
